// File: rtl/multicycle_ctrl_unit.sv
// Multicycle CPU control unit: sequences IF/ID/EXE/BR/AGEN/MEM/WB and decodes
// every datapath strobe from the state register and the current opcode.
module multicycle_ctrl_unit #(
  parameter int OP_W        = 6,
  parameter int ALUOP_W     = 3,
  parameter int MEM_WAIT_EN = 1
) (
  input  logic               clk,
  input  logic               RST,
  input  logic [OP_W-1:0]    opcode,
  input  logic               zero,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  output logic               PCWre,
  output logic [1:0]         PCSrc,
  output logic               IRWre,
  output logic               InsMemRW,
  output logic               DataMemEn,
  output logic               DataMemRW,
  output logic               RegWre,
  output logic               WrRegData,
  output logic               ALUM2Reg,
  output logic               ALUSrcB,
  output logic [1:0]         ExtSel,
  output logic [1:0]         RegOut,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [3:0]         state,
  output logic               halted,
  output logic               illegal
);

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_AGEN = 4'd2,
    S_MEM  = 4'd3,
    S_WBM  = 4'd4,
    S_BR   = 4'd5,
    S_EXE  = 4'd6,
    S_WBR  = 4'd7,
    S_HALT = 4'd8,
    S_TRAP = 4'd9
  } state_e;

  typedef enum logic [3:0] {
    C_ALU, C_SW, C_LW, C_BEQ, C_J, C_JR, C_JAL, C_HALT, C_ILL
  } class_e;

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;
  class_e     cls;
  logic [5:0] op6;
  logic       imem_rdy, dmem_rdy;

  logic       dec_wrreg, dec_m2reg, dec_srcb;
  logic [1:0] dec_ext, dec_regout;
  logic [2:0] dec_aluop;

  assign op6      = opcode[OP_W-1 -: 6];
  assign imem_rdy = (MEM_WAIT_EN != 0) ? imem_ready : 1'b1;
  assign dmem_rdy = (MEM_WAIT_EN != 0) ? dmem_ready : 1'b1;

  always_comb begin
    cls        = C_ILL;
    dec_wrreg  = 1'b0;
    dec_m2reg  = 1'b0;
    dec_srcb   = 1'b0;
    dec_ext    = 2'b00;
    dec_regout = 2'b00;
    dec_aluop  = 3'b000;
    case (op6)
      6'b000000: begin cls = C_ALU; dec_regout = 2'b10; dec_aluop = 3'b000; end
      6'b000001: begin cls = C_ALU; dec_regout = 2'b10; dec_aluop = 3'b001; end
      6'b000010: begin
        cls = C_ALU; dec_srcb = 1'b1; dec_ext = 2'b10; dec_regout = 2'b01; dec_aluop = 3'b000;
      end
      6'b010000: begin cls = C_ALU; dec_regout = 2'b10; dec_aluop = 3'b101; end
      6'b010001: begin cls = C_ALU; dec_regout = 2'b10; dec_aluop = 3'b110; end
      6'b010010: begin
        cls = C_ALU; dec_srcb = 1'b1; dec_ext = 2'b01; dec_regout = 2'b01; dec_aluop = 3'b101;
      end
      6'b011000: begin
        cls = C_ALU; dec_srcb = 1'b1; dec_ext = 2'b00; dec_regout = 2'b10; dec_aluop = 3'b100;
      end
      6'b100000: begin cls = C_ALU; dec_regout = 2'b10; dec_aluop = 3'b000; end
      6'b100111: begin cls = C_ALU; dec_regout = 2'b10; dec_aluop = 3'b010; end
      6'b110000: begin cls = C_SW; dec_srcb = 1'b1; dec_ext = 2'b10; end
      6'b110001: begin
        cls = C_LW; dec_srcb = 1'b1; dec_ext = 2'b10;
        dec_regout = 2'b01; dec_wrreg = 1'b1; dec_m2reg = 1'b1;
      end
      6'b110100: begin cls = C_BEQ; dec_ext = 2'b10; dec_aluop = 3'b111; end
      6'b111000: cls = C_J;
      6'b111001: cls = C_JR;
      6'b111010: cls = C_JAL;
      6'b111111: cls = C_HALT;
      default:   cls = C_ILL;
    endcase
    if (cls == C_ALU) dec_wrreg = 1'b1;
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IF;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IF:   if (imem_rdy) state_d = S_ID;
      S_ID: begin
        case (cls)
          C_J, C_JR, C_JAL: state_d = S_IF;
          C_ALU:            state_d = S_EXE;
          C_BEQ:            state_d = S_BR;
          C_SW, C_LW:       state_d = S_AGEN;
          C_HALT:           state_d = S_HALT;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EXE:  state_d = S_WBR;
      S_WBR:  state_d = S_IF;
      S_BR:   state_d = S_IF;
      S_AGEN: state_d = S_MEM;
      S_MEM:  if (dmem_rdy) state_d = (cls == C_LW) ? S_WBM : S_IF;
      S_WBM:  state_d = S_IF;
      S_HALT: state_d = S_HALT;
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_IF;
    endcase
  end

  always_comb begin
    PCWre     = 1'b0;
    PCSrc     = 2'b00;
    IRWre     = 1'b0;
    InsMemRW  = 1'b0;
    DataMemEn = 1'b0;
    DataMemRW = 1'b0;
    RegWre    = 1'b0;
    WrRegData = 1'b0;
    ALUM2Reg  = 1'b0;
    ALUSrcB   = 1'b0;
    ExtSel    = 2'b00;
    RegOut    = 2'b00;
    ALUOp     = '0;
    state     = state_q;
    halted    = (state_q == S_HALT);
    illegal   = illegal_q;

    // Decode fields hold for the whole instruction, from ID to its final state.
    if (state_q != S_IF && state_q != S_HALT && state_q != S_TRAP) begin
      WrRegData = dec_wrreg;
      ALUM2Reg  = dec_m2reg;
      ALUSrcB   = dec_srcb;
      ExtSel    = dec_ext;
      RegOut    = dec_regout;
      ALUOp     = ALUOP_W'(dec_aluop);
    end

    case (state_q)
      S_IF: IRWre = imem_rdy & RST;
      S_ID: begin
        case (cls)
          C_J:  begin PCWre = 1'b1; PCSrc = 2'b11; end
          C_JR: begin PCWre = 1'b1; PCSrc = 2'b10; end
          C_JAL: begin
            PCWre = 1'b1; PCSrc = 2'b11; RegWre = 1'b1;
            WrRegData = 1'b0; RegOut = 2'b00;
          end
          default: ;
        endcase
      end
      S_WBR, S_WBM: begin
        RegWre = 1'b1;
        PCWre  = 1'b1;
      end
      S_BR: begin
        PCWre = 1'b1;
        PCSrc = zero ? 2'b01 : 2'b00;
      end
      S_MEM: begin
        DataMemEn = 1'b1;
        DataMemRW = (cls == C_SW);
        if (dmem_rdy && cls == C_SW) PCWre = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// Directed bench for multicycle_ctrl_unit: walks each instruction class cycle
// by cycle and compares the full output vector against hand-derived values.
module tb_multicycle_ctrl_unit;

  logic       clk = 1'b0;
  logic       RST;
  logic [5:0] opcode;
  logic       zero, imem_ready, dmem_ready;
  logic       PCWre, IRWre, InsMemRW, DataMemEn, DataMemRW, RegWre;
  logic       WrRegData, ALUM2Reg, ALUSrcB, halted, illegal;
  logic [1:0] PCSrc, ExtSel, RegOut;
  logic [2:0] ALUOp;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl_unit #(.OP_W(6), .ALUOP_W(3), .MEM_WAIT_EN(1)) dut (
    .clk(clk), .RST(RST), .opcode(opcode), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .InsMemRW(InsMemRW),
    .DataMemEn(DataMemEn), .DataMemRW(DataMemRW), .RegWre(RegWre),
    .WrRegData(WrRegData), .ALUM2Reg(ALUM2Reg), .ALUSrcB(ALUSrcB),
    .ExtSel(ExtSel), .RegOut(RegOut), .ALUOp(ALUOp), .state(state),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  logic [23:0] obs_v;
  assign obs_v = {state, PCWre, PCSrc, IRWre, InsMemRW, DataMemEn, DataMemRW, RegWre,
                  WrRegData, ALUM2Reg, ALUSrcB, ExtSel, RegOut, ALUOp, halted, illegal};

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Expected vector: state, PCWre, PCSrc, IRWre, (InsMemRW=0), DataMemEn, DataMemRW,
  // RegWre, WrRegData, ALUM2Reg, ALUSrcB, ExtSel, RegOut, ALUOp, halted, illegal.
  task automatic chk(input string tag, input logic [3:0] st, input logic pcw,
                     input logic [1:0] pcs, input logic irw, input logic dme,
                     input logic dmrw, input logic rw, input logic wrd, input logic m2r,
                     input logic sb, input logic [1:0] ext, input logic [1:0] ro,
                     input logic [2:0] aop, input logic h, input logic il);
    logic [23:0] exp_v;
    #1;
    exp_v = {st, pcw, pcs, irw, 1'b0, dme, dmrw, rw, wrd, m2r, sb, ext, ro, aop, h, il};
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL %s: got %06h expected %06h", tag, obs_v, exp_v);
    end
  endtask

  task automatic fetch(input logic [5:0] op);
    opcode     = op;
    imem_ready = 1'b1;
    chk("if", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nxt();
  endtask

  task automatic run_alu(input string tag, input logic [5:0] op, input logic sb,
                         input logic [1:0] ext, input logic [1:0] ro, input logic [2:0] aop);
    fetch(op);
    chk({tag, "_id"},  1, 0, 0, 0, 0, 0, 0, 1, 0, sb, ext, ro, aop, 0, 0);
    nxt();
    chk({tag, "_exe"}, 6, 0, 0, 0, 0, 0, 0, 1, 0, sb, ext, ro, aop, 0, 0);
    nxt();
    chk({tag, "_wbr"}, 7, 1, 0, 0, 0, 0, 1, 1, 0, sb, ext, ro, aop, 0, 0);
    nxt();
  endtask

  initial begin
    RST = 1'b0; opcode = 6'b000000; zero = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
    repeat (3) begin
      nxt();
      chk("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    RST = 1'b1;

    run_alu("add", 6'b000000, 0, 2'b00, 2'b10, 3'b000);
    run_alu("ori", 6'b010010, 1, 2'b01, 2'b01, 3'b101);
    run_alu("sll", 6'b011000, 1, 2'b00, 2'b10, 3'b100);
    run_alu("slt", 6'b100111, 0, 2'b00, 2'b10, 3'b010);
    run_alu("sub", 6'b000001, 0, 2'b00, 2'b10, 3'b001);
    run_alu("and", 6'b010001, 0, 2'b00, 2'b10, 3'b110);
    run_alu("addi", 6'b000010, 1, 2'b10, 2'b01, 3'b000);

    fetch(6'b110001);
    chk("lw_id",   1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 2'b10, 2'b01, 0, 0, 0); nxt();
    chk("lw_agen", 2, 0, 0, 0, 0, 0, 0, 1, 1, 1, 2'b10, 2'b01, 0, 0, 0); nxt();
    chk("lw_mem",  3, 0, 0, 0, 1, 0, 0, 1, 1, 1, 2'b10, 2'b01, 0, 0, 0); nxt();
    chk("lw_wbm",  4, 1, 0, 0, 0, 0, 1, 1, 1, 1, 2'b10, 2'b01, 0, 0, 0); nxt();

    opcode = 6'b110000; imem_ready = 1'b0;
    chk("if_wait0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); nxt();
    chk("if_wait1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); nxt();
    fetch(6'b110000);
    dmem_ready = 1'b0;
    chk("sw_id",   1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 0, 0, 0); nxt();
    chk("sw_agen", 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 0, 0, 0); nxt();
    repeat (3) begin
      chk("sw_mem_wait", 3, 0, 0, 0, 1, 1, 0, 0, 0, 1, 2'b10, 0, 0, 0, 0); nxt();
    end
    dmem_ready = 1'b1;
    chk("sw_mem_rdy", 3, 1, 0, 0, 1, 1, 0, 0, 0, 1, 2'b10, 0, 0, 0, 0); nxt();

    fetch(6'b110100);
    zero = 1'b0;
    chk("beq1_id", 1, 0, 0,     0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 3'b111, 0, 0); nxt();
    zero = 1'b1;
    chk("beq1_br", 5, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 3'b111, 0, 0); nxt();
    fetch(6'b110100);
    zero = 1'b1;
    chk("beq0_id", 1, 0, 0,     0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 3'b111, 0, 0); nxt();
    zero = 1'b0;
    chk("beq0_br", 5, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 3'b111, 0, 0); nxt();

    fetch(6'b111010);
    chk("jal_id", 1, 1, 2'b11, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0); nxt();
    fetch(6'b111000);
    chk("j_id",   1, 1, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); nxt();
    fetch(6'b111001);
    chk("jr_id",  1, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); nxt();

    fetch(6'b110000);
    dmem_ready = 1'b0;
    nxt();
    nxt();
    chk("sw2_mem", 3, 0, 0, 0, 1, 1, 0, 0, 0, 1, 2'b10, 0, 0, 0, 0);
    #2 RST = 1'b0;
    chk("rst_in_mem",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); nxt();
    chk("rst_held_mem", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    RST = 1'b1; dmem_ready = 1'b1;

    fetch(6'b000111);
    chk("ill_id", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); nxt();
    opcode = 6'b111111;
    repeat (3) begin
      chk("trap", 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); nxt();
    end
    RST = 1'b0;
    chk("rst_trap", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); nxt();
    RST = 1'b1;

    fetch(6'b111111);
    chk("halt_id", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); nxt();
    for (int i = 0; i < 10; i++) begin
      imem_ready = i[0];
      dmem_ready = i[1];
      zero       = ~i[0];
      chk("halt", 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); nxt();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
